// File: rtl/platform_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | platform_timer_pkg : register offsets, CTRL bit indices, reset constants |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package platform_timer_pkg;

  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_MTIME     = 5'h04;
  localparam logic [4:0] ADDR_MTIMEH    = 5'h08;
  localparam logic [4:0] ADDR_MTIMECMP  = 5'h0C;
  localparam logic [4:0] ADDR_MTIMECMPH = 5'h10;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_DBGPAUSE_BIT = 1;

  localparam logic [1:0]  CTRL_RESET     = 2'b11;
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic is_mapped(input logic [4:0] offset);
    return (offset <= ADDR_MTIMECMPH);
  endfunction

endpackage : platform_timer_pkg
`default_nettype wire

// File: rtl/platform_timer_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | platform_timer_regs : APB decode, CTRL, MTIMECMP and MTIMEH shadow       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module platform_timer_regs
  import platform_timer_pkg::*;
#(
  parameter int W_ADDR = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [W_ADDR-1:0] i_paddr,
  input  logic [31:0]       i_pwdata,
  input  logic [63:0]       i_mtime,
  output logic [31:0]       o_prdata,
  output logic              o_pslverr,
  output logic              o_en,
  output logic              o_dbgpause,
  output logic [63:0]       o_mtimecmp,
  output logic              o_mtime_wr_lo,
  output logic              o_mtime_wr_hi
);

  logic [1:0]  r_ctrl;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_mtimeh_shadow;

  logic [4:0]  w_offset;
  logic        w_access;
  logic        w_wr;
  logic        w_rd;
  logic        w_unused_addr;

  assign w_offset      = {i_paddr[4:2], 2'b00};
  assign w_access      = i_psel && i_penable;
  assign w_wr          = w_access && i_pwrite;
  assign w_rd          = w_access && !i_pwrite;
  assign w_unused_addr = ^{i_paddr[W_ADDR-1:5], i_paddr[1:0]};

  assign o_mtime_wr_lo = w_wr && (w_offset == ADDR_MTIME);
  assign o_mtime_wr_hi = w_wr && (w_offset == ADDR_MTIMEH);
  assign o_en          = r_ctrl[CTRL_EN_BIT];
  assign o_dbgpause    = r_ctrl[CTRL_DBGPAUSE_BIT];
  assign o_mtimecmp    = r_mtimecmp;
  assign o_pslverr     = w_access && !is_mapped(w_offset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl          <= CTRL_RESET;
      r_mtimecmp      <= MTIMECMP_RESET;
      r_mtimeh_shadow <= 32'h0;
    end else begin
      if (w_wr && (w_offset == ADDR_CTRL))      r_ctrl <= i_pwdata[1:0];
      if (w_wr && (w_offset == ADDR_MTIMECMP))  r_mtimecmp[31:0] <= i_pwdata;
      if (w_wr && (w_offset == ADDR_MTIMECMPH)) r_mtimecmp[63:32] <= i_pwdata;
      // Latch the upper half with the lower-half read so a two-word read is coherent.
      if (w_rd && (w_offset == ADDR_MTIME))     r_mtimeh_shadow <= i_mtime[63:32];
    end
  end

  always_comb begin
    o_prdata = 32'h0;
    if (w_rd) begin
      case (w_offset)
        ADDR_CTRL:      o_prdata = {30'h0, r_ctrl};
        ADDR_MTIME:     o_prdata = i_mtime[31:0];
        ADDR_MTIMEH:    o_prdata = r_mtimeh_shadow;
        ADDR_MTIMECMP:  o_prdata = r_mtimecmp[31:0];
        ADDR_MTIMECMPH: o_prdata = r_mtimecmp[63:32];
        default:        o_prdata = 32'h0;
      endcase
    end
  end

endmodule : platform_timer_regs
`default_nettype wire

// File: rtl/platform_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | platform_timer : RISC-V mtime/mtimecmp timer with NRZ tick and APB slave |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module platform_timer
  import platform_timer_pkg::*;
#(
  parameter int W_ADDR = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_nrz,
  input  logic              dbg_halt,
  input  logic              apbs_psel,
  input  logic              apbs_penable,
  input  logic              apbs_pwrite,
  input  logic [W_ADDR-1:0] apbs_paddr,
  input  logic [31:0]       apbs_pwdata,
  output logic [31:0]       apbs_prdata,
  output logic              apbs_pready,
  output logic              apbs_pslverr,
  output logic              timer_irq
);

  logic        r_tick_prev;
  logic [63:0] r_mtime;
  logic        r_irq;

  logic        w_tick;
  logic        w_inc;
  logic        w_en;
  logic        w_dbgpause;
  logic [63:0] w_mtimecmp;
  logic        w_mtime_wr_lo;
  logic        w_mtime_wr_hi;

  platform_timer_regs #(
    .W_ADDR (W_ADDR)
  ) u_regs (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_psel        (apbs_psel),
    .i_penable     (apbs_penable),
    .i_pwrite      (apbs_pwrite),
    .i_paddr       (apbs_paddr),
    .i_pwdata      (apbs_pwdata),
    .i_mtime       (r_mtime),
    .o_prdata      (apbs_prdata),
    .o_pslverr     (apbs_pslverr),
    .o_en          (w_en),
    .o_dbgpause    (w_dbgpause),
    .o_mtimecmp    (w_mtimecmp),
    .o_mtime_wr_lo (w_mtime_wr_lo),
    .o_mtime_wr_hi (w_mtime_wr_hi)
  );

  assign apbs_pready = 1'b1;
  assign timer_irq   = r_irq;

  assign w_tick = tick_nrz ^ r_tick_prev;
  assign w_inc  = w_tick && w_en && !(w_dbgpause && dbg_halt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_prev <= 1'b0;
      r_mtime     <= 64'h0;
      r_irq       <= 1'b0;
    end else begin
      r_tick_prev <= tick_nrz;
      // A software write takes priority; a coincident tick is dropped with no carry.
      if (w_mtime_wr_lo)      r_mtime[31:0]  <= apbs_pwdata;
      else if (w_mtime_wr_hi) r_mtime[63:32] <= apbs_pwdata;
      else if (w_inc)         r_mtime        <= r_mtime + 64'd1;
      r_irq <= (r_mtime >= w_mtimecmp);
    end
  end

endmodule : platform_timer
`default_nettype wire

// File: tb/tb_platform_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_platform_timer : directed self-checking bench for platform_timer      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_platform_timer;

  logic        clk;
  logic        rst_n;
  logic        tick_nrz;
  logic        dbg_halt;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int n_checks;
  int n_errors;

  logic [31:0] rd;
  logic        er;

  platform_timer #(.W_ADDR(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_nrz     (tick_nrz),
    .dbg_halt     (dbg_halt),
    .apbs_psel    (psel),
    .apbs_penable (penable),
    .apbs_pwrite  (pwrite),
    .apbs_paddr   (paddr),
    .apbs_pwdata  (pwdata),
    .apbs_prdata  (prdata),
    .apbs_pready  (pready),
    .apbs_pslverr (pslverr),
    .timer_irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [19:0] a, input logic [31:0] d, input logic with_tick);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    if (with_tick) tick_nrz = ~tick_nrz;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    e = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic tick(input int gap);
    @(negedge clk);
    tick_nrz = ~tick_nrz;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; tick_nrz = 1'b0; dbg_halt = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_prdata_idle", prdata, 32'h0);
    check("rst_pready", {31'h0, pready}, 32'h1);
    apb_read(20'h00, rd, er);
    check("rst_ctrl", rd, 32'h3);
    check("rst_ctrl_slverr", {31'h0, er}, 32'h0);
    apb_read(20'h0C, rd, er);
    check("rst_mtimecmp", rd, 32'hFFFF_FFFF);
    apb_read(20'h10, rd, er);
    check("rst_mtimecmph", rd, 32'hFFFF_FFFF);

    // Tick counting
    for (int i = 0; i < 5; i++) tick(3);
    apb_read(20'h04, rd, er);
    check("count5_lo", rd, 32'd5);
    apb_read(20'h08, rd, er);
    check("count5_hi", rd, 32'd0);
    check("count5_irq", {31'h0, irq}, 32'h0);

    // Carry and atomic read
    apb_write(20'h04, 32'hFFFF_FFFF, 1'b0);
    apb_write(20'h08, 32'h0, 1'b0);
    tick(2);
    apb_read(20'h04, rd, er);
    check("carry_lo", rd, 32'h0);
    tick(2);
    apb_read(20'h08, rd, er);
    check("carry_hi_shadow", rd, 32'h1);
    apb_read(20'h04, rd, er);
    check("carry_lo_after", rd, 32'h1);

    // Interrupt rise
    apb_write(20'h04, 32'h0, 1'b0);
    apb_write(20'h08, 32'h0, 1'b0);
    apb_write(20'h0C, 32'h3, 1'b0);
    apb_write(20'h10, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("cmp3_irq_idle", {31'h0, irq}, 32'h0);
    tick(2);
    tick(2);
    check("cmp3_irq_at2", {31'h0, irq}, 32'h0);
    tick(1);
    check("cmp3_irq_edgeN", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("cmp3_irq_edgeN1", {31'h0, irq}, 32'h1);

    // Raising mtimecmp clears the interrupt one cycle after the write
    apb_write(20'h10, 32'h1, 1'b0);
    check("cmph_irq_edgeN", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    check("cmph_irq_edgeN1", {31'h0, irq}, 32'h0);

    // Wrap-around
    apb_write(20'h04, 32'hFFFF_FFFF, 1'b0);
    apb_write(20'h08, 32'hFFFF_FFFF, 1'b0);
    apb_write(20'h10, 32'h0, 1'b0);
    apb_write(20'h0C, 32'h1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_irq_before", {31'h0, irq}, 32'h1);
    tick(1);
    check("wrap_irq_edgeN", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    check("wrap_irq_edgeN1", {31'h0, irq}, 32'h0);
    apb_read(20'h04, rd, er);
    check("wrap_lo", rd, 32'h0);
    apb_read(20'h08, rd, er);
    check("wrap_hi", rd, 32'h0);

    // Write wins over a coincident increment
    apb_write(20'h04, 32'h100, 1'b1);
    apb_read(20'h04, rd, er);
    check("wr_vs_inc_lo", rd, 32'h100);
    apb_read(20'h08, rd, er);
    check("wr_vs_inc_hi", rd, 32'h0);

    // Debug pause and enable
    dbg_halt = 1'b1;
    for (int i = 0; i < 4; i++) tick(1);
    apb_read(20'h04, rd, er);
    check("pause_held", rd, 32'h100);
    apb_write(20'h00, 32'h1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1);
    apb_read(20'h04, rd, er);
    check("nopause_count", rd, 32'h104);
    apb_read(20'h00, rd, er);
    check("ctrl_rb", rd, 32'h1);
    dbg_halt = 1'b0;
    apb_write(20'h00, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1);
    apb_read(20'h04, rd, er);
    check("disabled_held", rd, 32'h104);
    apb_write(20'h00, 32'h3, 1'b0);

    // Unmapped offsets
    apb_read(20'h18, rd, er);
    check("unmapped_rd_data", rd, 32'h0);
    check("unmapped_rd_slverr", {31'h0, er}, 32'h1);
    apb_write(20'h14, 32'hDEAD_BEEF, 1'b0);
    apb_read(20'h14, rd, er);
    check("unmapped_wr_ignored", rd, 32'h0);
    apb_read(20'h0C, rd, er);
    check("unmapped_wr_no_alias", rd, 32'h1);

    // Asynchronous reset mid-count
    apb_write(20'h0C, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    tick(1);
    @(negedge clk);
    tick_nrz = ~tick_nrz;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    tick_nrz = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    apb_read(20'h04, rd, er);
    check("post_rst_mtime", rd, 32'h0);
    apb_read(20'h08, rd, er);
    check("post_rst_mtimeh", rd, 32'h0);
    apb_read(20'h00, rd, er);
    check("post_rst_ctrl", rd, 32'h3);
    apb_read(20'h0C, rd, er);
    check("post_rst_mtimecmp", rd, 32'hFFFF_FFFF);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_platform_timer
`default_nettype wire
